// File: rtl/fetch_unit.sv
// fetch_unit: PC generator feeding a DEPTH-entry {instr, pc} queue toward the decoder, with redirect flush.
// Ports: clk_i/rst_i (sync active-high) clock and reset; pc_addr_o/instr_i combinational imem lookup;
// redirect_i/redirect_pc_i branch redirect; valid_o/ready_i/instr_o/pc_o/pc_plus4_o head handshake; full_o queue full.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] pc_addr_o,
  input  logic [31:0] instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  logic [31:0] fpc;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [31:0] q_instr [DEPTH];
  logic [31:0] q_pc [DEPTH];
  logic pop, push;
  assign pc_addr_o  = fpc;
  assign valid_o    = count != '0;
  assign full_o     = count == DEPTH_C;
  assign pop        = valid_o & ready_i & ~redirect_i;
  assign push       = ~redirect_i & (~full_o | pop);
  assign instr_o    = valid_o ? q_instr[rd_ptr] : 32'h0;
  assign pc_o       = valid_o ? q_pc[rd_ptr] : 32'h0;
  assign pc_plus4_o = valid_o ? q_pc[rd_ptr] + 32'd4 : 32'h0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fpc    <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_i) begin
      fpc    <= {redirect_pc_i[31:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      fpc    <= push ? fpc + 32'd4 : fpc;
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // Entry storage needs no reset: stale slots are never visible because outputs are masked by valid_o.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      q_instr[wr_ptr] <= instr_i;
      q_pc[wr_ptr]    <= fpc;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a word[n]=n instruction memory.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst, redirect, ready, valid, full;
  logic [31:0] pc_addr, instr, redirect_pc, instr_out, pc, pc_plus4;
  int n = 0;
  int errs = 0;
  always #5 clk = ~clk;
  assign instr = {2'b00, pc_addr[31:2]};
  fetch_unit dut (
    .clk_i(clk), .rst_i(rst), .pc_addr_o(pc_addr), .instr_i(instr),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .valid_o(valid),
    .ready_i(ready), .instr_o(instr_out), .pc_o(pc), .pc_plus4_o(pc_plus4), .full_o(full)
  );
  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b0;
    cyc; cyc;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_pc_addr", pc_addr, 32'h0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h0);
    rst = 1'b0; ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc;
      chk("stream_valid", 32'(valid), 32'd1);
      chk("stream_pc", pc, 32'(4 * i));
      chk("stream_instr", instr_out, 32'(i));
      chk("stream_pc_addr", pc_addr, 32'(4 * i + 4));
    end
    rst = 1'b1; ready = 1'b0;
    cyc;
    rst = 1'b0;
    cyc; cyc;
    chk("bp2_full", 32'(full), 32'd0);
    cyc; cyc;
    chk("bp4_full", 32'(full), 32'd1);
    chk("bp4_pc_addr", pc_addr, 32'd16);
    chk("bp4_pc", pc, 32'd0);
    cyc;
    chk("bp_hold_pc_addr", pc_addr, 32'd16);
    chk("bp_hold_pc", pc, 32'd0);
    chk("bp_hold_instr", instr_out, 32'd0);
    chk("bp_hold_full", 32'(full), 32'd1);
    ready = 1'b1;
    cyc;
    ready = 1'b0;
    chk("fullpop_full", 32'(full), 32'd1);
    chk("fullpop_pc_addr", pc_addr, 32'd20);
    chk("fullpop_pc", pc, 32'd4);
    chk("fullpop_instr", instr_out, 32'd1);
    cyc;
    chk("fullpop_one_pc", pc, 32'd4);
    rst = 1'b1;
    cyc;
    rst = 1'b0;
    cyc; cyc; cyc;
    redirect = 1'b1; redirect_pc = 32'h0000_0046; ready = 1'b1;
    cyc;
    redirect = 1'b0; ready = 1'b0;
    chk("redir_valid", 32'(valid), 32'd0);
    chk("redir_pc_addr", pc_addr, 32'h44);
    cyc;
    chk("redir_head_valid", 32'(valid), 32'd1);
    chk("redir_head_pc", pc, 32'h44);
    chk("redir_head_pc4", pc_plus4, 32'h48);
    chk("redir_head_instr", instr_out, 32'h11);
    redirect = 1'b1; redirect_pc = 32'h100;
    cyc;
    redirect_pc = 32'h203;
    cyc;
    redirect = 1'b0;
    chk("b2b_valid", 32'(valid), 32'd0);
    chk("b2b_pc_addr", pc_addr, 32'h200);
    cyc;
    chk("b2b_pc", pc, 32'h200);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; ready = 1'b1;
    cyc;
    redirect = 1'b0;
    chk("wrap_pc_addr", pc_addr, 32'hFFFF_FFF8);
    cyc;
    chk("wrap_pc0", pc, 32'hFFFF_FFF8);
    chk("wrap_pc4_0", pc_plus4, 32'hFFFF_FFFC);
    cyc;
    chk("wrap_pc1", pc, 32'hFFFF_FFFC);
    chk("wrap_pc4_1", pc_plus4, 32'h0);
    cyc;
    chk("wrap_pc2", pc, 32'h0);
    chk("wrap_valid", 32'(valid), 32'd1);
    chk("wrap_instr", instr_out, 32'h0);
    rst = 1'b1; ready = 1'b0;
    cyc;
    rst = 1'b0;
    cyc; cyc;
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
    cyc;
    chk("rstredir_valid", 32'(valid), 32'd0);
    chk("rstredir_pc_addr", pc_addr, 32'h0);
    chk("rstredir_full", 32'(full), 32'd0);
    chk("rstredir_pc", pc, 32'h0);
    rst = 1'b0; redirect = 1'b0; ready = 1'b1;
    cyc;
    chk("release_valid", 32'(valid), 32'd1);
    chk("release_pc", pc, 32'h0);
    chk("release_pc_addr", pc_addr, 32'h4);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
